// File: rtl/inv_2x2_sched.sv
// inv_2x2_sched: launch/capture sequencer for the 2x2 matrix-inverse datapath.
// Define INV_HOLD_TIMEOUT_EN to drop a result left unconsumed for HOLD_MAX cycles.
module inv_2x2_sched #(
   parameter int DW       = 64,
   parameter int LATENCY  = 103,
   parameter int HOLD_MAX = 916
) (
   input  logic          I_sys_clk,
   input  logic          I_sys_rstn,
   input  logic [DW-1:0] I_A11,
   input  logic [DW-1:0] I_A12,
   input  logic [DW-1:0] I_A21,
   input  logic [DW-1:0] I_A22,
   input  logic          I_A_valid,
   output logic          O_A_ready,
   output logic [DW-1:0] O_dp_A11,
   output logic [DW-1:0] O_dp_A12,
   output logic [DW-1:0] O_dp_A21,
   output logic [DW-1:0] O_dp_A22,
   output logic          O_dp_start,
   input  logic [DW-1:0] I_dp_A11_inv,
   input  logic [DW-1:0] I_dp_A12_inv,
   input  logic [DW-1:0] I_dp_A21_inv,
   input  logic [DW-1:0] I_dp_A22_inv,
   input  logic          I_dp_singular,
   output logic [DW-1:0] O_A11_inv_final,
   output logic [DW-1:0] O_A12_inv_final,
   output logic [DW-1:0] O_A21_inv_final,
   output logic [DW-1:0] O_A22_inv_final,
   output logic          O_singular,
   output logic          O_A_inv_valid,
   input  logic          I_A_inv_ready,
   input  logic          I_flush,
   output logic          O_busy,
   output logic          O_drop
);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

   localparam logic [11:0] LAT_C     = 12'(LATENCY);
   localparam logic [11:0] HOLD_LAST = 12'(HOLD_MAX - 1);

   state_t      state, state_nxt;
   logic [11:0] cnt, cnt_nxt;
   logic        accept, capture, consume, timeout;

   assign O_A_ready  = (state == IDLE) && !I_flush;
   assign O_dp_start = (state == LAUNCH);
   assign O_busy     = (state != IDLE);
   assign accept     = O_A_ready && I_A_valid;
   assign capture    = (state == WAIT) && (cnt == LAT_C) && !I_flush;
   assign consume    = (state == HOLD) && I_A_inv_ready && !I_flush;

`ifdef INV_HOLD_TIMEOUT_EN
   assign timeout = (state == HOLD) && !I_A_inv_ready && !I_flush
                    && (cnt == HOLD_LAST);
`else
   logic unused_hold;
   assign unused_hold = ^HOLD_LAST;
   assign timeout     = 1'b0;
`endif

   assign O_drop = timeout;

   always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
      if (!I_sys_rstn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (I_flush) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (I_A_valid) state_nxt = LAUNCH;
            end
            LAUNCH: begin
               cnt_nxt   = 12'd1;
               state_nxt = WAIT;
            end
            WAIT: begin
               if (cnt == LAT_C) begin
                  cnt_nxt   = '0;
                  state_nxt = HOLD;
               end else begin
                  cnt_nxt = cnt + 12'd1;
               end
            end
            HOLD: begin
               if (I_A_inv_ready || timeout) begin
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
`ifdef INV_HOLD_TIMEOUT_EN
                  cnt_nxt = cnt + 12'd1;
`endif
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
      if (!I_sys_rstn) begin
         O_dp_A11        <= '0;
         O_dp_A12        <= '0;
         O_dp_A21        <= '0;
         O_dp_A22        <= '0;
         O_A11_inv_final <= '0;
         O_A12_inv_final <= '0;
         O_A21_inv_final <= '0;
         O_A22_inv_final <= '0;
         O_singular      <= 1'b0;
         O_A_inv_valid   <= 1'b0;
      end else begin
         if (accept) begin
            O_dp_A11 <= I_A11;
            O_dp_A12 <= I_A12;
            O_dp_A21 <= I_A21;
            O_dp_A22 <= I_A22;
         end
         if (I_flush || timeout) begin
            O_A11_inv_final <= '0;
            O_A12_inv_final <= '0;
            O_A21_inv_final <= '0;
            O_A22_inv_final <= '0;
            O_singular      <= 1'b0;
            O_A_inv_valid   <= 1'b0;
         end else if (capture) begin
            O_A11_inv_final <= I_dp_A11_inv;
            O_A12_inv_final <= I_dp_A12_inv;
            O_A21_inv_final <= I_dp_A21_inv;
            O_A22_inv_final <= I_dp_A22_inv;
            O_singular      <= I_dp_singular;
            O_A_inv_valid   <= 1'b1;
         end else if (consume) begin
            O_singular    <= 1'b0;
            O_A_inv_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_inv_2x2_sched.sv
// tb_inv_2x2_sched: scoreboard bench with a delayed-result datapath model.
// Build with +define+INV_HOLD_TIMEOUT_EN to exercise the hold timeout.
module tb_inv_2x2_sched;

   localparam int DW   = 64;
   localparam int LAT  = 103;
   localparam int HMAX = 916;
   localparam logic [DW-1:0] NAN = 64'h7FF8_0000_0000_0000;

   typedef struct packed {
      int                   acc;
      logic [3:0][DW-1:0]   v;
      logic                 sing;
   } exp_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [DW-1:0] I_A11 = '0, I_A12 = '0, I_A21 = '0, I_A22 = '0;
   logic          I_A_valid = 1'b0;
   logic          O_A_ready;
   logic [DW-1:0] O_dp_A11, O_dp_A12, O_dp_A21, O_dp_A22;
   logic          O_dp_start;
   logic [DW-1:0] dp11 = '0, dp12 = '0, dp21 = '0, dp22 = '0;
   logic          dp_sing = 1'b0;
   logic [DW-1:0] r11, r12, r21, r22;
   logic          O_singular, O_A_inv_valid;
   logic          I_A_inv_ready = 1'b0;
   logic          I_flush = 1'b0;
   logic          O_busy, O_drop;

   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   last_acc = 0;
   int   last_cons = 0;
   int   rdy_mode = 2;
   int   cur_a[4];
   exp_t sb[$];

   inv_2x2_sched #(.DW(DW), .LATENCY(LAT), .HOLD_MAX(HMAX)) dut (
      .I_sys_clk(clk), .I_sys_rstn(rstn),
      .I_A11(I_A11), .I_A12(I_A12), .I_A21(I_A21), .I_A22(I_A22),
      .I_A_valid(I_A_valid), .O_A_ready(O_A_ready),
      .O_dp_A11(O_dp_A11), .O_dp_A12(O_dp_A12),
      .O_dp_A21(O_dp_A21), .O_dp_A22(O_dp_A22),
      .O_dp_start(O_dp_start),
      .I_dp_A11_inv(dp11), .I_dp_A12_inv(dp12),
      .I_dp_A21_inv(dp21), .I_dp_A22_inv(dp22),
      .I_dp_singular(dp_sing),
      .O_A11_inv_final(r11), .O_A12_inv_final(r12),
      .O_A21_inv_final(r21), .O_A22_inv_final(r22),
      .O_singular(O_singular), .O_A_inv_valid(O_A_inv_valid),
      .I_A_inv_ready(I_A_inv_ready), .I_flush(I_flush),
      .O_busy(O_busy), .O_drop(O_drop)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Mathematical inverse of integer matrix, as IEEE doubles.
   function automatic exp_t ref_inv(input int a[4]);
      exp_t e;
      int   det;
      real  d;
      e     = '0;
      det   = a[0] * a[3] - a[1] * a[2];
      if (det == 0) begin
         e.v    = {NAN, NAN, NAN, NAN};
         e.sing = 1'b1;
      end else begin
         d        = $itor(det);
         e.v[0]   = $realtobits($itor(a[3]) / d);
         e.v[1]   = $realtobits($itor(-a[1]) / d);
         e.v[2]   = $realtobits($itor(-a[2]) / d);
         e.v[3]   = $realtobits($itor(a[0]) / d);
         e.sing   = 1'b0;
      end
      return e;
   endfunction

   function automatic logic [DW-1:0] junk();
      return {$urandom, $urandom};
   endfunction

   // Datapath model: result valid only in the cycle LAT after start.
   initial begin
      int   dp_age;
      int   ops[4];
      exp_t dpe;
      dp_age = -1;
      dpe    = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            dp_age = -1;
         end else if (O_dp_start) begin
            chk("start_cyc", 64'(cyc), 64'(last_acc + 1));
            chk("dp_a11", O_dp_A11, DW'(cur_a[0]));
            chk("dp_a12", O_dp_A12, DW'(cur_a[1]));
            chk("dp_a21", O_dp_A21, DW'(cur_a[2]));
            chk("dp_a22", O_dp_A22, DW'(cur_a[3]));
            ops    = '{int'(O_dp_A11), int'(O_dp_A12),
                       int'(O_dp_A21), int'(O_dp_A22)};
            dpe    = ref_inv(ops);
            dp_age = 0;
         end else if (dp_age >= 0) begin
            dp_age++;
         end
         if (dp_age == LAT) begin
            dp11 = dpe.v[0]; dp12 = dpe.v[1];
            dp21 = dpe.v[2]; dp22 = dpe.v[3];
            dp_sing = dpe.sing;
         end else begin
            dp11 = junk(); dp12 = junk(); dp21 = junk(); dp22 = junk();
            dp_sing = 1'($urandom);
         end
      end
   end

   initial forever begin
      @(negedge clk);
      #1;
      unique case (rdy_mode)
         0:       I_A_inv_ready = ($urandom_range(0, 99) < 35);
         1:       I_A_inv_ready = 1'b0;
         default: I_A_inv_ready = 1'b1;
      endcase
   end

   // Monitor: result timing, values, hold stability, consume and flush.
   initial begin
      bit            prev_v, chk_cons, chk_fl;
      logic [DW-1:0] h[4];
      logic          hs;
      exp_t          e;
      prev_v = 0; chk_cons = 0; chk_fl = 0;
      h = '{default: '0}; hs = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!rstn) begin
            prev_v = 0; chk_cons = 0; chk_fl = 0;
            continue;
         end
         if (chk_cons) begin
            chk("cons_valid", 64'(O_A_inv_valid), 64'd0);
            chk("cons_ready", 64'(O_A_ready), 64'd1);
            chk("cons_sing", 64'(O_singular), 64'd0);
            chk_cons = 0;
         end
         if (chk_fl) begin
            chk("flush_valid", 64'(O_A_inv_valid), 64'd0);
            chk("flush_r11", r11, '0);
            chk("flush_r22", r22, '0);
            chk("flush_sing", 64'(O_singular), 64'd0);
            chk("flush_busy", 64'(O_busy), 64'd0);
            chk_fl = 0;
         end
         if (O_A_inv_valid) begin
            if (!prev_v) begin
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_valid: got 1 want 0 (cycle %0d)", cyc);
               end else begin
                  e = sb[0];
                  chk("rise_cyc", 64'(cyc), 64'(e.acc + 2 + LAT));
                  chk("res_a11", r11, e.v[0]);
                  chk("res_a12", r12, e.v[1]);
                  chk("res_a21", r21, e.v[2]);
                  chk("res_a22", r22, e.v[3]);
                  chk("res_sing", 64'(O_singular), 64'(e.sing));
               end
               h  = '{r11, r12, r21, r22};
               hs = O_singular;
            end else begin
               chk("hold_a11", r11, h[0]);
               chk("hold_a22", r22, h[3]);
               chk("hold_a12", r12 ^ r21, h[1] ^ h[2]);
               chk("hold_sing", 64'(O_singular), 64'(hs));
               chk("hold_ready", 64'(O_A_ready), 64'd0);
            end
            if (I_A_inv_ready && !I_flush) begin
               if (sb.size() != 0) void'(sb.pop_front());
               chk_cons  = 1;
               last_cons = cyc;
            end
         end
         if (I_flush) chk_fl = 1;
         prev_v = O_A_inv_valid;
      end
   end

   task automatic send(input int a[4]);
      exp_t e;
      bit   ok;
      ok = 0;
      @(negedge clk);
      I_A11 = DW'(a[0]); I_A12 = DW'(a[1]);
      I_A21 = DW'(a[2]); I_A22 = DW'(a[3]);
      I_A_valid = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         #1;
         if (O_A_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got ready 0 want 1");
      end else begin
         cur_a    = a;
         last_acc = cyc;
         e        = ref_inv(a);
         e.acc    = last_acc;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      I_A_valid = 1'b0;
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (O_A_inv_valid) break;
      end
      chk("wait_valid", 64'(O_A_inv_valid), 64'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!O_busy) break;
      end
      chk("wait_idle", 64'(O_busy), 64'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a[4];
      #12;
      chk("rst_valid", 64'(O_A_inv_valid), 64'd0);
      chk("rst_start", 64'(O_dp_start), 64'd0);
      chk("rst_sing", 64'(O_singular), 64'd0);
      chk("rst_drop", 64'(O_drop), 64'd0);
      chk("rst_dp", O_dp_A11 | O_dp_A12 | O_dp_A21 | O_dp_A22, '0);
      chk("rst_res", r11 | r12 | r21 | r22, '0);
      #11;
      rstn = 1'b1;
      @(negedge clk);
      #2;
      chk("rel_busy", 64'(O_busy), 64'd0);
      chk("rel_ready", 64'(O_A_ready), 64'd1);

      // diagonal matrix, consumer always ready
      rdy_mode = 2;
      send('{2, 0, 0, 4});
      wait_idle();

      // consumer stalls 50 cycles while a second matrix waits
      rdy_mode = 1;
      send('{3, 1, 1, 2});
      wait_valid();
      I_A11 = 64'd1; I_A12 = 64'd1; I_A21 = 64'd0; I_A22 = 64'd1;
      I_A_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         chk("stall_ready", 64'(O_A_ready), 64'd0);
      end
      @(negedge clk);
      rdy_mode = 2;
      send('{1, 1, 0, 1});
      chk("acc_after_cons", 64'(last_acc), 64'(last_cons + 1));
      wait_idle();

      // singular matrix
      send('{1, 2, 2, 4});
      wait_idle();

      // flush in WAIT at cnt=40
      rdy_mode = 1;
      send('{5, 3, 2, 7});
      while (cyc < last_acc + 41) @(negedge clk);
      I_flush = 1'b1;
      @(negedge clk);
      I_flush = 1'b0;
      sb.delete();
      while (cyc < last_acc + 120) @(negedge clk);

      // flush in HOLD coincident with consumer ready
      send('{4, 1, 2, 3});
      wait_valid();
      @(negedge clk);
      rdy_mode = 2;
      I_flush  = 1'b1;
      @(negedge clk);
      I_flush  = 1'b0;
      rdy_mode = 1;
      sb.delete();
      wait_idle();

      // asynchronous reset mid-WAIT
      rdy_mode = 2;
      send('{6, 2, 1, 3});
      while (cyc < last_acc + 50) @(negedge clk);
      #3;
      rstn = 1'b0;
      #1;
      chk("arst_busy", 64'(O_busy), 64'd0);
      chk("arst_dp", O_dp_A11 | O_dp_A12 | O_dp_A21 | O_dp_A22, '0);
      chk("arst_start", 64'(O_dp_start), 64'd0);
      sb.delete();
      @(negedge clk);
      #3;
      rstn = 1'b1;
      send('{7, 3, 5, 2});
      wait_idle();

      // randomized matrices with a random consumer
      rdy_mode = 0;
      for (int n = 0; n < 25; n++) begin
         if (n % 5 == 4) begin
            a[0] = $urandom_range(1, 3);
            a = '{a[0], 2 * a[0], 1, 2};
         end else begin
            for (int k = 0; k < 4; k++) a[k] = $urandom_range(0, 7);
         end
         send(a);
      end
      rdy_mode = 2;
      wait_idle();

      // consumer never ready
      rdy_mode = 1;
      send('{2, 1, 1, 1});
`ifdef INV_HOLD_TIMEOUT_EN
      while (cyc < last_acc + 1019) @(negedge clk);
      #2;
      chk("to_pre_drop", 64'(O_drop), 64'd0);
      chk("to_pre_valid", 64'(O_A_inv_valid), 64'd1);
      @(negedge clk);
      #2;
      chk("to_drop", 64'(O_drop), 64'd1);
      @(negedge clk);
      #2;
      chk("to_post_valid", 64'(O_A_inv_valid), 64'd0);
      chk("to_post_drop", 64'(O_drop), 64'd0);
      chk("to_post_res", r11 | r12 | r21 | r22, '0);
      chk("to_post_busy", 64'(O_busy), 64'd0);
      sb.delete();
`else
      while (cyc < last_acc + 2000) @(negedge clk);
      #2;
      chk("nto_valid", 64'(O_A_inv_valid), 64'd1);
      chk("nto_busy", 64'(O_busy), 64'd1);
      chk("nto_drop", 64'(O_drop), 64'd0);
      @(negedge clk);
      rdy_mode = 2;
      wait_idle();
`endif
      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
